// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Brief    : RISC-V MEM stage - req/ack data-memory port, store lane
//            formatting, load extraction and pipeline stall/bubble control.
//            Optional build macro: MISALIGN_TRAP_EN (flag misaligned H/W
//            accesses instead of silently aligning them).
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] write_data_in,
    input  logic [1:0]  control_wb_in,
    input  logic [4:0]  write_reg_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall,
    output logic [1:0]  control_wb_out,
    output logic [31:0] read_data_out,
    output logic [31:0] alu_result_out,
    output logic [4:0]  write_reg_out,
    output logic        misaligned
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] c_SZ_B = 2'd0;
    localparam logic [1:0] c_SZ_H = 2'd1;
    localparam logic [1:0] c_SZ_W = 2'd2;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_off;
    logic [31:0] r_read_data;

    logic        w_access;
    logic        w_trap;
    logic        w_issue;
    logic [1:0]  w_size;
    logic [1:0]  w_off;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_lane_b;
    logic [15:0] w_lane_h;
    logic [31:0] w_load;

    assign w_access = memread | memwrite;

    // Undefined funct3 codes fall through to full-word behaviour.
    always_comb begin
        w_size = c_SZ_W;
        case (funct3)
            3'b000, 3'b100: w_size = c_SZ_B;
            3'b001, 3'b101: w_size = c_SZ_H;
            default:        w_size = c_SZ_W;
        endcase
    end

    // Lane offset with the low bits forced to natural alignment for H and W.
    always_comb begin
        w_off = alu_result_in[1:0];
        if (w_size == c_SZ_H) begin
            w_off = {alu_result_in[1], 1'b0};
        end else if (w_size == c_SZ_W) begin
            w_off = 2'b00;
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic w_misalign_raw;
    assign w_misalign_raw = ((w_size == c_SZ_H) && alu_result_in[0]) ||
                            ((funct3 == 3'b010) && (alu_result_in[1:0] != 2'b00));
    assign w_trap = w_misalign_raw;
`else
    assign w_trap = 1'b0;
`endif

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = write_data_in;
        case (w_size)
            c_SZ_B: begin
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{write_data_in[7:0]}};
            end
            c_SZ_H: begin
                w_be    = w_off[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{write_data_in[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = write_data_in;
            end
        endcase
    end

    // Load extraction uses the size/offset captured at issue time.
    always_comb begin
        w_lane_b = dmem_rdata[7:0];
        case (r_off)
            2'd0:    w_lane_b = dmem_rdata[7:0];
            2'd1:    w_lane_b = dmem_rdata[15:8];
            2'd2:    w_lane_b = dmem_rdata[23:16];
            default: w_lane_b = dmem_rdata[31:24];
        endcase
        w_lane_h = r_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    end

    always_comb begin
        w_load = dmem_rdata;
        case (r_size)
            c_SZ_B:  w_load = r_unsigned ? {24'd0, w_lane_b}
                                         : {{24{w_lane_b[7]}}, w_lane_b};
            c_SZ_H:  w_load = r_unsigned ? {16'd0, w_lane_h}
                                         : {{16{w_lane_h[15]}}, w_lane_h};
            default: w_load = dmem_rdata;
        endcase
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_issue        = 1'b0;
        dmem_req       = 1'b0;
        stall          = 1'b0;
        misaligned     = 1'b0;
        control_wb_out = control_wb_in;
        read_data_out  = 32'd0;
        case (r_state)
            IDLE: begin
                if (w_access) begin
                    control_wb_out = 2'b00;
                    if (w_trap) begin
                        misaligned = 1'b1;
                    end else begin
                        stall       = 1'b1;
                        w_issue     = 1'b1;
                        w_state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                dmem_req       = 1'b1;
                stall          = 1'b1;
                control_wb_out = 2'b00;
                if (dmem_ack) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                read_data_out = r_read_data;
                // Always retire to IDLE so the held EX/MEM instruction is not re-issued.
                w_state_nxt   = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_be        <= 4'd0;
            r_we        <= 1'b0;
            r_size      <= 2'd0;
            r_unsigned  <= 1'b0;
            r_off       <= 2'd0;
            r_read_data <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_issue) begin
                r_addr     <= {alu_result_in[31:2], 2'b00};
                r_wdata    <= w_wdata;
                r_be       <= w_be;
                r_we       <= memwrite;
                r_size     <= w_size;
                r_unsigned <= funct3[2];
                r_off      <= w_off;
            end
            if ((r_state == WAIT) && dmem_ack) begin
                r_read_data <= w_load;
            end
        end
    end

    assign dmem_addr      = r_addr;
    assign dmem_wdata     = r_wdata;
    assign dmem_be        = r_be;
    assign dmem_we        = r_we;
    assign alu_result_out = alu_result_in;
    assign write_reg_out  = write_reg_in;

endmodule
`default_nettype wire
